// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two
// execution pipelines, with a registered write stage and a contention counter.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mux_sel,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              prio_q, prio_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              mux_sel_q, mux_sel_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
  logic              contend;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // prio_q names the pipe that wins when both request
  always_comb begin
    wb0_ready = en & wb0_valid & (~wb1_valid | ~prio_q);
    wb1_ready = en & wb1_valid & (~wb0_valid |  prio_q);
    contend   = en & wb0_valid & wb1_valid;
  end

  always_comb begin
    prio_d         = prio_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    mux_sel_d      = mux_sel_q;
    conflict_cnt_d = conflict_cnt_q;
    if (wb0_ready) begin
      // r0 writes are consumed but never reach the register file
      rf_we_d    = |wb0_rd;
      rf_waddr_d = wb0_rd;
      rf_wdata_d = wb0_data;
      mux_sel_d  = 1'b0;
      prio_d     = 1'b1;
    end else if (wb1_ready) begin
      rf_we_d    = |wb1_rd;
      rf_waddr_d = wb1_rd;
      rf_wdata_d = wb1_data;
      mux_sel_d  = 1'b1;
      prio_d     = 1'b0;
    end
    if (contend) conflict_cnt_d = sat_inc(conflict_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q         <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      mux_sel_q      <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      prio_q         <= prio_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      mux_sel_q      <= mux_sel_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign mux_sel      = mux_sel_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus hand-written
// reset, saturation and asynchronous-reset sequences.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mux_sel;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mux_sel(mux_sel),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic        en;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_sel;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
    en = e; wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
  endtask

  initial begin
    // en v0 rd0 d0 | v1 rd1 d1 | r0 r1 | we addr data sel cnt
    vecs[0]  = '{1, 1, 3, 32'hDEADBEEF, 0, 0, 0,     1, 0, 1, 3, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 1, 7, 32'hA1,           0, 1, 1, 7, 32'hA1, 1, 0};
    vecs[2]  = '{1, 0, 0, 0, 1, 8, 32'hA2,           0, 1, 1, 8, 32'hA2, 1, 0};
    vecs[3]  = '{1, 0, 0, 0, 1, 9, 32'hA3,           0, 1, 1, 9, 32'hA3, 1, 0};
    vecs[4]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,      1, 0, 1, 1, 32'h11, 0, 1};
    vecs[5]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,      0, 1, 1, 2, 32'h22, 1, 2};
    vecs[6]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,      1, 0, 1, 1, 32'h11, 0, 3};
    vecs[7]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,      0, 1, 1, 2, 32'h22, 1, 4};
    vecs[8]  = '{1, 1, 0, 32'hFFFFFFFF, 0, 0, 0,     1, 0, 0, 0, 32'hFFFFFFFF, 0, 4};
    vecs[9]  = '{0, 1, 4, 32'h44, 1, 5, 32'h55,      0, 0, 0, 0, 32'hFFFFFFFF, 0, 4};
    vecs[10] = '{0, 1, 4, 32'h44, 1, 5, 32'h55,      0, 0, 0, 0, 32'hFFFFFFFF, 0, 4};
    vecs[11] = '{1, 1, 4, 32'h44, 1, 5, 32'h55,      0, 1, 1, 5, 32'h55, 1, 5};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 0,                0, 0, 0, 5, 32'h55, 1, 5};
    vecs[13] = '{1, 1, 6, 32'h66, 0, 0, 0,           1, 0, 1, 6, 32'h66, 0, 5};
    vecs[14] = '{1, 1, 10, 32'h77, 0, 0, 0,          1, 0, 1, 10, 32'h77, 0, 5};
    vecs[15] = '{1, 1, 11, 32'h88, 1, 12, 32'h99,    0, 1, 1, 12, 32'h99, 1, 6};

    // Reset held with both pipes requesting
    rst_n = 1'b0;
    drive(0, 1, 3, 32'hDEADBEEF, 1, 4, 32'h44);
    @(posedge clk); #1;
    check("rst_we", 32'(rf_we), 0);
    check("rst_sel", 32'(mux_sel), 0);
    check("rst_cnt", 32'(conflict_cnt), 0);
    check("rst_addr", 32'(rf_waddr), 0);
    check("rst_r0_en0", 32'(wb0_ready), 0);
    check("rst_r1_en0", 32'(wb1_ready), 0);
    en = 1'b1; #1;
    check("rst_r0_en1", 32'(wb0_ready), 1);
    check("rst_r1_en1", 32'(wb1_ready), 0);
    @(posedge clk); #1;
    check("rst_hold_we", 32'(rf_we), 0);
    check("rst_hold_cnt", 32'(conflict_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1);
      #2;
      check($sformatf("v%0d_ready0", i), 32'(wb0_ready), 32'(vecs[i].e_r0));
      check($sformatf("v%0d_ready1", i), 32'(wb1_ready), 32'(vecs[i].e_r1));
      @(posedge clk); #1;
      check($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_data);
      check($sformatf("v%0d_sel", i), 32'(mux_sel), 32'(vecs[i].e_sel));
      check($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(vecs[i].e_cnt));
    end

    // Long contention run drives the counter into saturation
    drive(1, 1, 1, 32'h11, 1, 2, 32'h22);
    repeat (65540) @(posedge clk);
    #1;
    check("sat_cnt", 32'(conflict_cnt), 32'hFFFF);
    @(posedge clk); #1;
    check("sat_nowrap", 32'(conflict_cnt), 32'hFFFF);
    check("sat_we", 32'(rf_we), 1);

    // Asynchronous reset between edges while a grant is pending
    drive(1, 1, 13, 32'hCAFE, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(rf_we), 0);
    check("arst_waddr", 32'(rf_waddr), 0);
    check("arst_wdata", rf_wdata, 0);
    check("arst_sel", 32'(mux_sel), 0);
    check("arst_cnt", 32'(conflict_cnt), 0);
    @(posedge clk); #1;
    check("arst_edge_we", 32'(rf_we), 0);
    check("arst_edge_addr", 32'(rf_waddr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_we", 32'(rf_we), 1);
    check("post_rst_waddr", 32'(rf_waddr), 13);
    check("post_rst_wdata", rf_wdata, 32'hCAFE);
    check("post_rst_sel", 32'(mux_sel), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
